// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX path.
//   arb_state_t : TX arbiter state encoding
//   ETH_IFG_BYTES, ETH_CLK_HZ : line constants (GMII byte clock domain)
//   sat_inc     : saturating increment for the arbiter's 12-bit counters
package eth_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_SEND  = 2'd2,
    ARB_GAP   = 2'd3
  } arb_state_t;

  localparam int ETH_IFG_BYTES = 12;
  localparam int ETH_CLK_HZ    = 125000000;
  localparam int ARB_CNT_W     = 12;

  function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v);
    return (&v) ? v : v + ARB_CNT_W'(1);
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// Round-robin selector: first set bit of req_i at or after ptr_i, wrapping
// modulo N. Purely combinational.
//   req_i   : candidate bitmap
//   ptr_i   : search start position (0..N-1)
//   valid_o : at least one candidate present
//   idx_o   : chosen candidate index
module rr_pick
  import eth_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Walk offsets from far to near so the nearest hit (offset 0 first) wins.
  always_comb begin
    int k;
    valid_o = 1'b0;
    idx_o   = '0;
    k       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr_i) + i) % N;
      if (req_i[k]) begin
        valid_o = 1'b1;
        idx_o   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares one GMII TX byte stream between N packet senders.
// One sender is granted at a time (round-robin), its bytes are muxed onto the
// PHY with zero latency, a minimum inter-frame gap is enforced, and a grant is
// abandoned if the sender never starts or never finishes.
//   clk, rst_n    : TX byte clock, async active-low reset
//   i_req         : per-sender level request
//   i_ready       : per-sender idle flag (falls when a packet starts)
//   i_data/_en    : per-sender byte lanes, sender k on bits [8k+7:8k]
//   o_start       : one-hot start strobe to the granted sender (START only)
//   o_data/tx_en  : muxed TX byte and enable
//   o_busy        : arbiter not idle
//   o_grant_idx   : current/last granted sender
//   o_timeout     : single-cycle pulse when a START or SEND timeout fires
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int N          = 3,
  parameter int IFG_CYCLES = ETH_IFG_BYTES,
  parameter int START_TMO  = 1024,
  parameter int SEND_TMO   = 2048
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   i_req,
  input  logic [N-1:0]   i_ready,
  input  logic [8*N-1:0] i_data,
  input  logic [N-1:0]   i_data_en,
  output logic [N-1:0]   o_start,
  output logic [7:0]     o_data,
  output logic           o_tx_en,
  output logic           o_busy,
  output logic [2:0]     o_grant_idx,
  output logic           o_timeout
);

  localparam logic [ARB_CNT_W-1:0] START_LAST = ARB_CNT_W'(START_TMO - 1);
  localparam logic [ARB_CNT_W-1:0] SEND_LAST  = ARB_CNT_W'(SEND_TMO - 1);
  localparam logic [ARB_CNT_W-1:0] GAP_LAST   = ARB_CNT_W'(IFG_CYCLES - 1);
  localparam logic [2:0]           LAST_IDX   = 3'(N - 1);

  arb_state_t state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [ARB_CNT_W-1:0] start_cnt_q, start_cnt_d;
  logic [ARB_CNT_W-1:0] send_cnt_q, send_cnt_d;
  logic [ARB_CNT_W-1:0] gap_cnt_q, gap_cnt_d;

  logic [N-1:0]      eligible;
  logic              pick_valid;
  logic [2:0]        pick_idx;
  logic [N-1:0][7:0] data_arr;
  logic [N-1:0]      grant_oh;
  logic [7:0]        sel_data;
  logic              sel_ready;
  logic              sel_en;
  logic              fwd;

  // A sender that is still busy (ready low) cannot be granted.
  assign eligible = i_req & i_ready;
  assign data_arr = i_data;

  rr_pick #(
    .N  (N),
    .IW (3)
  ) u_rr_pick (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Lane select for the registered grant. Only the granted lane is ever
  // visible, so a timed-out sender that keeps driving is silently dropped.
  always_comb begin
    grant_oh  = '0;
    sel_data  = 8'h00;
    sel_ready = 1'b0;
    sel_en    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (grant_q == 3'(k)) begin
        grant_oh[k] = 1'b1;
        sel_data    = data_arr[k];
        sel_ready   = i_ready[k];
        sel_en      = i_data_en[k];
      end
    end
  end

  // Next-state and timeout decode.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    o_timeout = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_idx;
          rr_ptr_d = (pick_idx == LAST_IDX) ? 3'd0 : pick_idx + 3'd1;
          state_d  = ARB_START;
        end
      end
      ARB_START: begin
        // Ready falling wins over a coincident timeout: the sender did start.
        if (!sel_ready) begin
          state_d = ARB_SEND;
        end else if (start_cnt_q == START_LAST) begin
          o_timeout = 1'b1;
          state_d   = ARB_GAP;
        end
      end
      ARB_SEND: begin
        if (sel_ready) begin
          state_d = ARB_GAP;
        end else if (send_cnt_q == SEND_LAST) begin
          o_timeout = 1'b1;
          state_d   = ARB_GAP;
        end
      end
      ARB_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Per-state cycle counters: zero on any state change, saturating otherwise.
  always_comb begin
    start_cnt_d = '0;
    send_cnt_d  = '0;
    gap_cnt_d   = '0;
    if (state_d == state_q) begin
      if (state_q == ARB_START) start_cnt_d = sat_inc(start_cnt_q);
      if (state_q == ARB_SEND)  send_cnt_d  = sat_inc(send_cnt_q);
      if (state_q == ARB_GAP)   gap_cnt_d   = sat_inc(gap_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      start_cnt_q <= '0;
      send_cnt_q  <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      start_cnt_q <= start_cnt_d;
      send_cnt_q  <= send_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // START forwards too: a sender may put its first byte out as ready falls.
  // Everything below decodes the state register, so reset silences the PHY
  // immediately.
  assign fwd         = (state_q == ARB_START) || (state_q == ARB_SEND);
  assign o_data      = fwd ? sel_data : 8'h00;
  assign o_tx_en     = fwd & sel_en;
  assign o_start     = (state_q == ARB_START) ? grant_oh : '0;
  assign o_busy      = (state_q != ARB_IDLE);
  assign o_grant_idx = grant_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
module tb_eth_tx_arbiter;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   i_req;
  logic [N-1:0]   i_ready;
  logic [8*N-1:0] i_data;
  logic [N-1:0]   i_data_en;
  logic [N-1:0]   o_start;
  logic [7:0]     o_data;
  logic           o_tx_en, o_busy, o_timeout;
  logic [2:0]     o_grant_idx;

  always #5 clk = ~clk;

  eth_tx_arbiter #(.N(N), .IFG_CYCLES(12), .START_TMO(1024), .SEND_TMO(2048)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_ready(i_ready), .i_data(i_data),
    .i_data_en(i_data_en), .o_start(o_start), .o_data(o_data), .o_tx_en(o_tx_en),
    .o_busy(o_busy), .o_grant_idx(o_grant_idx), .o_timeout(o_timeout)
  );

  // ---------------- sender models (one process drives all lanes) ----------
  logic [N-1:0] s_ready, s_en;
  logic [7:0]   s_data [N];
  int  cfg_len [N];
  bit  cfg_stuck_start [N], cfg_stuck_send [N], cfg_force_low [N];
  int  mdl_gen = 0;
  int  m_st [N], m_b [N];

  bit             ovr_on = 1'b0;
  logic [8*N-1:0] ovr_data = '0;
  logic [N-1:0]   ovr_en = '0;

  assign i_ready   = s_ready;
  assign i_data    = ovr_on ? ovr_data : {s_data[2], s_data[1], s_data[0]};
  assign i_data_en = ovr_on ? ovr_en : s_en;

  function automatic logic [7:0] pat(input int k, input int b);
    return 8'((k * 64 + b) & 255);
  endfunction

  initial begin
    int gen;
    gen = 0;
    s_ready = '1;
    s_en = '0;
    for (int k = 0; k < N; k++) begin s_data[k] = 8'h00; m_st[k] = 0; m_b[k] = 0; end
    forever begin
      @(posedge clk); #1;
      if (mdl_gen != gen) begin
        gen = mdl_gen;
        for (int k = 0; k < N; k++) begin
          m_st[k] = 0; s_ready[k] = 1'b1; s_en[k] = 1'b0; s_data[k] = 8'h00;
        end
      end
      for (int k = 0; k < N; k++) begin
        case (m_st[k])
          0: begin
            s_en[k] = 1'b0; s_data[k] = 8'h00; s_ready[k] = !cfg_force_low[k];
            if (o_start[k] && !cfg_stuck_start[k] && !cfg_force_low[k]) m_st[k] = 1;
          end
          1: begin  // ready falls and first byte goes out in the same cycle
            s_ready[k] = 1'b0; s_en[k] = 1'b1; s_data[k] = pat(k, 0); m_b[k] = 1; m_st[k] = 2;
          end
          default: begin
            if (m_b[k] < cfg_len[k] || cfg_stuck_send[k]) begin
              s_en[k] = 1'b1; s_data[k] = pat(k, m_b[k]); m_b[k]++;
            end else begin
              s_en[k] = 1'b0; s_data[k] = 8'h00; s_ready[k] = 1'b1; m_st[k] = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- monitor ----------------------------------------------
  int mon_gen = 0;
  int grants[$], start_lens[$], gaps[$];
  logic [7:0] rx[$];
  int to_cnt, to_at, start_run, low_run, grant_cyc;
  bit seen_frame;

  initial begin
    int g;
    g = -1;
    forever begin
      @(negedge clk);
      if (mon_gen != g) begin
        g = mon_gen;
        grants.delete(); start_lens.delete(); gaps.delete(); rx.delete();
        to_cnt = 0; to_at = 0; start_run = 0; low_run = 0; grant_cyc = 0; seen_frame = 0;
      end
      if (o_start != '0) begin
        if (start_run == 0) begin
          for (int k = 0; k < N; k++) if (o_start[k]) grants.push_back(k);
          grant_cyc = 0;
        end
        start_run++;
      end else if (start_run != 0) begin
        start_lens.push_back(start_run);
        start_run = 0;
      end
      grant_cyc++;
      if (o_timeout) begin to_cnt++; to_at = grant_cyc; end
      if (o_tx_en) begin
        rx.push_back(o_data);
        if (seen_frame && low_run != 0) gaps.push_back(low_run);
        low_run = 0; seen_frame = 1;
      end else begin
        low_run++;
      end
    end
  end

  // ---------------- checking helpers --------------------------------------
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic nstep();
    @(negedge clk); #1;
  endtask

  task automatic wait_start(input int k, input int lim);
    bit ok;
    ok = 0;
    for (int c = 0; c < lim; c++) begin
      nstep();
      if (o_start[k]) begin ok = 1; break; end
    end
    chk($sformatf("wait_start%0d", k), ok, 1);
  endtask

  task automatic wait_idle(input int lim);
    bit ok;
    ok = 0;
    for (int c = 0; c < lim; c++) begin
      nstep();
      if (!o_busy) begin ok = 1; break; end
    end
    chk("wait_idle", ok, 1);
  endtask

  task automatic wait_grants(input int n, input int lim);
    bit ok;
    ok = 0;
    for (int c = 0; c < lim; c++) begin
      nstep();
      if (grants.size() >= n) begin ok = 1; break; end
    end
    chk($sformatf("wait_grants%0d", n), ok, 1);
  endtask

  function automatic int byte_errs(input int base, input int k, input int len);
    int e;
    e = 0;
    for (int b = 0; b < len; b++)
      if (base + b >= rx.size() || rx[base + b] !== pat(k, b)) e++;
    return e;
  endfunction

  typedef struct {
    logic [8*N-1:0] data;
    logic [N-1:0]   en;
    logic [7:0]     exp_data;
    logic           exp_en;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence -----------------------------------------
  initial begin
    bit ok;
    int cnt, txc, bad;

    tbl[0] = '{24'hC3B2A1, 3'b100, 8'hC3, 1'b1};
    tbl[1] = '{24'h112233, 3'b011, 8'h11, 1'b0};
    tbl[2] = '{24'h00FFFF, 3'b011, 8'h00, 1'b0};
    tbl[3] = '{24'h5A0000, 3'b111, 8'h5A, 1'b1};
    tbl[4] = '{24'hFF0102, 3'b100, 8'hFF, 1'b1};

    for (int k = 0; k < N; k++) begin
      cfg_len[k] = 64; cfg_stuck_start[k] = 0; cfg_stuck_send[k] = 0; cfg_force_low[k] = 0;
    end
    i_req = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) nstep();

    // reset values
    chk("rst_start", o_start, 0);
    chk("rst_data", o_data, 0);
    chk("rst_tx_en", o_tx_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_grant_idx", o_grant_idx, 0);
    chk("rst_timeout", o_timeout, 0);
    rst_n = 1'b1;
    nstep();

    // contention: all three request, 64-byte frames
    mon_gen++;
    i_req = 3'b111;
    wait_grants(6, 1000);
    i_req = '0;
    wait_idle(300);
    chk("cont_ngrants", grants.size(), 6);
    for (int f = 0; f < 6 && f < grants.size(); f++) chk($sformatf("cont_grant%0d", f), grants[f], f % 3);
    bad = 0;
    for (int f = 0; f < start_lens.size(); f++) if (start_lens[f] != 2) bad++;
    chk("cont_start_lens", bad, 0);
    chk("cont_rx_len", rx.size(), 384);
    bad = 0;
    for (int f = 0; f < 6 && f < grants.size(); f++) bad += byte_errs(f * 64, grants[f], 64);
    chk("cont_bytes", bad, 0);
    chk("cont_ngaps", gaps.size(), 5);
    bad = 0;
    for (int f = 0; f < gaps.size(); f++) if (gaps[f] != 15) bad++;
    chk("cont_gap_len", bad, 0);

    // single request from sender 1, request dropped right after the grant
    mon_gen++;
    cfg_len[1] = 60;
    i_req = 3'b010;
    wait_start(1, 20);
    i_req = '0;
    ok = 0;
    for (int c = 0; c < 20; c++) begin nstep(); if (!s_ready[1]) begin ok = 1; break; end end
    chk("single_ready_fall", ok, 1);
    ok = 0;
    for (int c = 0; c < 200; c++) begin nstep(); if (s_ready[1]) begin ok = 1; break; end end
    chk("single_ready_rise", ok, 1);
    cnt = 0; txc = 0;
    for (int c = 0; c < 40; c++) begin
      nstep(); cnt++;
      if (!o_busy) break;
      if (o_tx_en) txc++;
    end
    chk("single_busy_low_cycle", cnt, 13);
    chk("single_gap_tx_en", txc, 0);
    chk("single_grants", grants.size(), 1);
    chk("single_start_len", (start_lens.size() > 0) ? start_lens[0] : -1, 2);
    chk("single_rx_len", rx.size(), 60);
    chk("single_bytes", byte_errs(0, 1, 60), 0);
    repeat (3) nstep();
    chk("single_grant_hold", o_grant_idx, 1);
    chk("single_stay_idle", o_busy, 0);

    // ineligible: sender 0 requests while its ready is low
    mon_gen++;
    cfg_force_low[0] = 1;
    cfg_len[0] = 8;
    repeat (2) nstep();
    i_req = 3'b001;
    bad = 0;
    for (int c = 0; c < 6; c++) begin nstep(); if (o_busy || o_start != '0) bad++; end
    chk("inelig_idle", bad, 0);
    cfg_force_low[0] = 0;
    nstep();
    chk("inelig_ready_cycle_busy", o_busy, 0);
    nstep();
    chk("inelig_start_next", o_start, 3'b001);
    i_req = '0;
    wait_idle(100);
    chk("inelig_grant_idx", o_grant_idx, 0);
    chk("inelig_rx_len", rx.size(), 8);

    // start timeout on sender 2, then sender 0 served
    mon_gen++;
    cfg_stuck_start[2] = 1;
    i_req = 3'b101;
    wait_start(2, 20);
    for (int v = 0; v < 5; v++) begin
      nstep();
      ovr_on = 1; ovr_data = tbl[v].data; ovr_en = tbl[v].en;
      #1;
      chk($sformatf("mux%0d_data", v), o_data, tbl[v].exp_data);
      chk($sformatf("mux%0d_en", v), o_tx_en, tbl[v].exp_en);
      ovr_on = 0;
    end
    ok = 0;
    for (int c = 0; c < 1100; c++) begin nstep(); if (o_timeout) begin ok = 1; break; end end
    chk("stmo_pulse_seen", ok, 1);
    chk("stmo_pulse_in_start", o_start, 3'b100);
    nstep();
    ovr_on = 1; ovr_data = '1; ovr_en = '1;
    #1;
    chk("gap_tx_en_masked", o_tx_en, 0);
    chk("gap_data_zero", o_data, 0);
    chk("gap_busy", o_busy, 1);
    chk("gap_no_start", o_start, 0);
    chk("stmo_pulse_width", o_timeout, 0);
    ovr_on = 0;
    wait_grants(2, 100);
    i_req = '0;
    wait_idle(100);
    chk("stmo_grant0", (grants.size() > 0) ? grants[0] : -1, 2);
    chk("stmo_grant1", (grants.size() > 1) ? grants[1] : -1, 0);
    chk("stmo_start_len", (start_lens.size() > 0) ? start_lens[0] : -1, 1024);
    chk("stmo_count", to_cnt, 1);
    chk("stmo_at", to_at, 1024);
    cfg_stuck_start[2] = 0;

    // send timeout on sender 0, which keeps transmitting afterwards
    mon_gen++;
    cfg_stuck_send[0] = 1;
    i_req = 3'b001;
    wait_start(0, 20);
    i_req = '0;
    ok = 0;
    for (int c = 0; c < 2200; c++) begin nstep(); if (o_timeout) begin ok = 1; break; end end
    chk("sdtmo_pulse_seen", ok, 1);
    txc = 0;
    for (int c = 0; c < 30; c++) begin nstep(); if (o_tx_en) txc++; end
    chk("sdtmo_masked", txc, 0);
    chk("sdtmo_idle", o_busy, 0);
    chk("sdtmo_count", to_cnt, 1);
    chk("sdtmo_at", to_at, 2050);
    chk("sdtmo_rx_len", rx.size(), 2049);

    // another sender while sender 0 still drives its lane
    mon_gen++;
    cfg_len[1] = 4;
    i_req = 3'b010;
    wait_start(1, 20);
    i_req = '0;
    wait_idle(100);
    chk("mask_rx_len", rx.size(), 4);
    chk("mask_bytes", byte_errs(0, 1, 4), 0);
    cfg_stuck_send[0] = 0;
    mdl_gen++;
    repeat (3) nstep();

    // reset mid-frame; pending requests re-served from pointer 0
    mon_gen++;
    cfg_len[1] = 64;
    i_req = 3'b010;
    ok = 0;
    for (int c = 0; c < 100; c++) begin nstep(); if (rx.size() >= 20) begin ok = 1; break; end end
    chk("rstmid_reach_byte20", ok, 1);
    chk("rstmid_tx_before", o_tx_en, 1);
    i_req = 3'b110;
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_tx_en", o_tx_en, 0);
    chk("rstmid_data", o_data, 0);
    chk("rstmid_start", o_start, 0);
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_grant_idx", o_grant_idx, 0);
    mdl_gen++;
    repeat (3) nstep();
    mon_gen++;
    rst_n = 1'b1;
    wait_grants(1, 10);
    i_req = '0;
    chk("rstmid_regrant", (grants.size() > 0) ? grants[0] : -1, 1);
    wait_idle(200);
    chk("rstmid_rx_len", rx.size(), 64);
    chk("rstmid_bytes", byte_errs(0, 1, 64), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
